// File: rtl/conv_pkg.sv
//------------------------------------------------------------------------------
// Module  : conv_pkg
// Brief   : Shared sample type, limits and helpers for the conv pipeline.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package conv_pkg;

    localparam int SAMPLE_W = 8;
    localparam int CONV_N   = 128;
    localparam int CONV_M   = 32;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam sample_t SAMPLE_MIN = sample_t'(1 << (SAMPLE_W - 1));

    // Number of valid outputs of a length-n by length-m convolution
    function automatic int calc_l(input int n, input int m);
        return n - m + 1;
    endfunction

    localparam int CONV_L = calc_l(CONV_N, CONV_M);

    // Ties keep the first operand
    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (b > a) ? b : a;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pool_ctr.sv
//------------------------------------------------------------------------------
// Module  : pool_ctr
// Brief   : Pool window and frame position counters; flags window close.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pool_ctr #(
    parameter int P = 2,
    parameter int L = 97
) (
    input  logic clk,
    input  logic reset,
    input  logic fire,
    output logic close,
    output logic last
);

    localparam int c_win_w = (P > 1) ? $clog2(P) : 1;
    localparam int c_frm_w = (L > 1) ? $clog2(L) : 1;

    localparam logic [c_win_w-1:0] c_win_last = c_win_w'(P - 1);
    localparam logic [c_frm_w-1:0] c_frm_last = c_frm_w'(L - 1);

    logic [c_win_w-1:0] r_win_cnt;
    logic [c_frm_w-1:0] r_frm_cnt;

    assign last  = (r_frm_cnt == c_frm_last);
    assign close = (r_win_cnt == c_win_last) | last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_cnt <= '0;
            r_frm_cnt <= '0;
        end else if (fire) begin
            r_win_cnt <= close ? '0 : r_win_cnt + c_win_w'(1);
            r_frm_cnt <= last  ? '0 : r_frm_cnt + c_frm_w'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/maxpool_1d_stream.sv
//------------------------------------------------------------------------------
// Module  : maxpool_1d_stream
// Brief   : Streaming non-overlapping 1-D max pool over conv output frames.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module maxpool_1d_stream
    import conv_pkg::*;
#(
    parameter int T = SAMPLE_W,
    parameter int N = CONV_N,
    parameter int M = CONV_M,
    parameter int P = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid_y,
    output logic                s_ready_y,
    input  logic signed [T-1:0] s_data_in_y,
    output logic                m_valid_z,
    input  logic                m_ready_z,
    output logic signed [T-1:0] m_data_out_z,
    output logic                m_last_z
);

    localparam int c_l = calc_l(N, M);

    localparam logic signed [T-1:0] c_sample_min = {1'b1, {(T-1){1'b0}}};

    logic                r_valid;
    logic                r_last;
    logic signed [T-1:0] r_data;
    logic signed [T-1:0] r_acc;

    logic                w_acc_fire;
    logic                w_close;
    logic                w_last;
    logic signed [T-1:0] w_max;

    // A held result blocks input only until the same-cycle consume
    assign s_ready_y  = ~r_valid | m_ready_z;
    assign w_acc_fire = s_valid_y & s_ready_y;
    assign w_max      = (s_data_in_y > r_acc) ? s_data_in_y : r_acc;

    pool_ctr #(
        .P (P),
        .L (c_l)
    ) u_pool_ctr (
        .clk   (clk),
        .reset (reset),
        .fire  (w_acc_fire),
        .close (w_close),
        .last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_acc   <= c_sample_min;
        end else begin
            if (r_valid && m_ready_z) begin
                r_valid <= 1'b0;
            end
            if (w_acc_fire) begin
                if (w_close) begin
                    r_data  <= w_max;
                    r_last  <= w_last;
                    r_valid <= 1'b1;
                    r_acc   <= c_sample_min;
                end else begin
                    r_acc   <= w_max;
                end
            end
        end
    end

    assign m_valid_z    = r_valid;
    assign m_data_out_z = r_data;
    assign m_last_z     = r_last;

endmodule

`default_nettype wire
